station_array: RTL

//  Parametrised pool of DEPTH reservation-station entries between instruction decode, LSU and scheduler.

---
 rtl/station_array.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/station_array.sv
// Reservation-station pool: DEPTH entries, each with its own iop micro-step FSM.
// The oldest ready entry (by allocation order) is offered to the scheduler every cycle.
module station_array #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IOP_W  = 32,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              id_feed,
    input  logic [IOP_W-1:0]  id_iop,
    input  logic [2:0]        id_iop_init,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_k16,
    output logic              id_ready,
    output logic [TAG_W-1:0]  id_tag,
    input  logic              lsu_wb,
    input  logic [TAG_W-1:0]  lsu_tag,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              r_valid,
    output logic [TAG_W-1:0]  r_tag,
    output logic [2:0]        r_state,
    output logic [IOP_W-1:0]  r_iop,
    output logic [DATA_W-1:0] r_pc,
    output logic [DATA_W-1:0] r_k16,
    output logic              r_ld_mem,
    output logic              r_st_mem,
    output logic              r_will_complete,
    input  logic              sched_ack,
    output logic [TAG_W:0]    occupancy
);

    localparam int unsigned OCC_W = TAG_W + 1;

    typedef enum logic [2:0] {
        FREE   = 3'b000,
        WAIT_1 = 3'b001,
        WAIT_2 = 3'b010,
        WAIT_3 = 3'b011,
        LOAD_0 = 3'b100,
        LOAD_1 = 3'b101,
        ALU    = 3'b110,
        STORE  = 3'b111
    } state_t;

    state_t            st_q   [DEPTH];
    logic [IOP_W-1:0]  iop_q  [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] k16_q  [DEPTH];
    // older_q[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]  older_q [DEPTH];

    logic [DEPTH-1:0]  sel;
    logic [DEPTH-1:0]  ack_v;
    logic [DEPTH-1:0]  wb_hit;
    logic              alloc;

    // Free-slot search and occupancy, from registered state only
    always_comb begin
        id_ready  = 1'b0;
        id_tag    = '0;
        occupancy = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (st_q[i] == FREE) begin
                id_ready = 1'b1;
                id_tag   = TAG_W'(i);
            end else begin
                occupancy = occupancy + OCC_W'(1);
            end
        end
    end

    assign alloc = id_feed & id_ready;

    // Oldest-ready select and offered-entry fields
    always_comb begin
        logic [2:0] st;
        sel             = '0;
        r_valid         = 1'b0;
        r_tag           = '0;
        r_state         = '0;
        r_iop           = '0;
        r_pc            = '0;
        r_k16           = '0;
        st              = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sel[i] = st_q[i][2];
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (st_q[j][2] && older_q[j][i]) sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel[i]) begin
                r_valid = 1'b1;
                r_tag   = TAG_W'(i);
                st      = st_q[i];
                r_iop   = iop_q[i];
                r_pc    = pc_q[i];
                r_k16   = k16_q[i];
            end
        end
        r_state         = st;
        r_ld_mem        = r_valid && (st[2:1] == 2'b10);
        r_st_mem        = r_valid && (st == STORE);
        r_will_complete = r_valid && ((st == STORE) ||
                                      (st == LOAD_1 && r_iop[28]) ||
                                      (st == ALU && !r_iop[23]));
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ack_v[i]  = sched_ack && sel[i];
            wb_hit[i] = lsu_wb && (lsu_tag == TAG_W'(i)) && (st_q[i] != FREE);
        end
    end

    // Per-entry micro-step FSMs, payload and age matrix
    always_ff @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i]    <= FREE;
                iop_q[i]   <= '0;
                pc_q[i]    <= '0;
                k16_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                case (st_q[i])
                    FREE:    if (alloc && id_tag == TAG_W'(i)) st_q[i] <= state_t'(id_iop_init);
                    WAIT_1:  if (wb_hit[i]) st_q[i] <= LOAD_1;
                    WAIT_2:  if (wb_hit[i]) st_q[i] <= ALU;
                    WAIT_3:  st_q[i] <= STORE;
                    LOAD_0:  if (ack_v[i]) st_q[i] <= WAIT_1;
                    LOAD_1:  if (ack_v[i]) st_q[i] <= iop_q[i][28] ? FREE : WAIT_2;
                    ALU:     if (ack_v[i]) st_q[i] <= iop_q[i][23] ? STORE : FREE;
                    STORE:   if (ack_v[i]) st_q[i] <= FREE;
                    default: st_q[i] <= FREE;
                endcase

                if (alloc && id_tag == TAG_W'(i)) begin
                    iop_q[i] <= id_iop;
                    pc_q[i]  <= id_pc;
                    k16_q[i] <= id_k16;
                end else if (wb_hit[i]) begin
                    k16_q[i] <= lsu_data;
                end

                // New entry is younger than everyone: clear its row, set its column
                for (int j = 0; j < int'(DEPTH); j++) begin
                    if (alloc) begin
                        if (id_tag == TAG_W'(i))      older_q[i][j] <= 1'b0;
                        else if (id_tag == TAG_W'(j)) older_q[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
